inst_rom: RTL and testbench
===========================

Name: inst_rom

Overview:
Instruction memory that terminates the core's instruction-fetch interface as its slave/responder end. It answers fetch requests combinationally from a word array.
- Contains a sequential program-loader FSM.
- The loader assembles a big-endian byte stream (e.g. from a UART or testbench) into 32-bit words and writes them from word 0 upward.
- It sits beside the CPU top in the SoC wrapper: CPU fetch master -> inst_rom fetch slave.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, >= 4)
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0
NOP_INST, 32'h0000_0000, instruction returned when no valid data can be supplied

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
fetch.en  input  1  fetch request enable (i_fetch_inst slave modport)
fetch.addr  input  32  fetch byte address
fetch.data  output  32  instruction word (inst_t)
load_start  input  1  one-cycle pulse: begin a program load
load_len  input  16  number of words to load, sampled on load_start
load_valid  input  1  load_byte is valid this cycle
load_byte  input  8  program byte, most significant byte of each word first
load_ready  output  1  byte accepted this cycle when load_valid && load_ready
load_busy  output  1  loader in LOAD state
load_done  output  1  one-cycle pulse: load completed
load_err  output  1  sticky: load_len > DEPTH_WORDS requested; cleared by next accepted load_start

Behaviour:
- Reset (rst low, async):
  - state=IDLE; byte_cnt=0; word_cnt=0; len_q=0.
  - load_ready=0, load_busy=0, load_done=0, load_err=0.
  - The array is NOT cleared; contents survive reset.
- Fetch path, purely combinational, zero latency:
  - idx = (addr - BASE_ADDR) >> 2.
  - data = mem[idx] when en=1, state!=LOAD, addr[1:0]==0 and (addr - BASE_ADDR) < DEPTH_WORDS*4.
  - Otherwise data = NOP_INST: en=0, misaligned, out of range, below BASE_ADDR (unsigned wrap makes it out of range), or a load in progress.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: on load_start:
    - If load_len > DEPTH_WORDS: stay IDLE and set load_err.
    - Else clear load_err, capture len_q, clear counters, and go to LOAD (or DONE directly if load_len==0).
  - LOAD:
    - load_ready=1, load_busy=1.
    - Each accepted byte shifts into the assembly register: asm <= {asm[23:0], byte}; byte_cnt increments mod 4.
    - On the 4th byte: mem[word_cnt] <= {asm[23:0], byte} on the same edge; word_cnt++.
    - If word_cnt+1 == len_q, go to DONE.
    - load_start is ignored while in LOAD.
  - DONE: load_done=1 for exactly one cycle, load_ready=0, then go to IDLE.
- A load_valid beat without load_ready (IDLE/DONE) is dropped silently.
- The fetch port may read a word in the first cycle after DONE; the write is already committed.
- Reset mid-load: returns to IDLE immediately; words already written are kept; a partial word in the assembly register is discarded.
- Simultaneous load_start and load_valid in IDLE: the byte is dropped (ready=0 that cycle).
- Counter widths: word_cnt is clog2(DEPTH_WORDS)+1 bits so that len_q == DEPTH_WORDS completes without wrap.

Decomposition:
- The shared project_types package gets:
  - loader_state_t enum {LD_IDLE, LD_LOAD, LD_DONE};
  - constant INST_NOP;
  - inst_t and addr width, which already exist there.
- One natural sub-module: byte_word_packer. It does the 8->32 big-endian assembly with byte_cnt and emits a word_valid pulse. The FSM and array stay in inst_rom.

Test Plan:
- Reset with rst=0 mid-cycle -> all load outputs 0 asynchronously; fetch en=1 addr=0 returns prior contents (not cleared).
- load_start, load_len=2, bytes 34 01 00 0A 34 02 00 14 -> load_done pulse one cycle after 8th byte. Then fetch addr 0 -> 32'h3401000A, addr 4 -> 32'h34020014.
- During LOAD, fetch en=1 addr=0 -> NOP_INST; load_start pulsed again mid-load -> ignored, word_cnt unchanged.
- Fetch addr 32'h2 (misaligned), addr DEPTH_WORDS*4 (out of range), en=0 -> NOP_INST in each case.
- load_len=DEPTH_WORDS+1 -> load_err=1, state stays IDLE. Then load_len=0 -> load_err clears, load_done pulses next cycle, no writes.
- Reset after 6 of 8 bytes -> word 0 written, word 1 unchanged, state IDLE. A new load then restarts at word 0.

Source files
------------

// File: rtl/inst_rom_pkg.sv
// Shared fetch-side types and loader state encoding used by the instruction ROM.
package inst_rom_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [INST_W-1:0] inst_t;

  localparam inst_t INST_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_DONE
  } loader_state_t;

endpackage

// File: rtl/inst_rom_byte_word_packer.sv
// Packs a big-endian byte stream into 32-bit words, pulsing word_valid_o on the 4th byte.
module inst_rom_byte_word_packer
  import inst_rom_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_i,
  output inst_t      word_o,
  output logic       word_valid_o
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] asm_q, asm_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    if (clear_i) begin
      byte_cnt_d = '0;
      asm_d      = '0;
    end else if (byte_valid_i) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      asm_d      = {asm_q[15:0], byte_i};
    end
  end

  // The completed word is presented on the same cycle as its final byte.
  assign word_o       = {asm_q, byte_i};
  assign word_valid_o = byte_valid_i && !clear_i && (byte_cnt_q == 2'd3);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_cnt_q <= '0;
      asm_q      <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
    end
  end

endmodule

// File: rtl/inst_rom.sv
// Instruction memory: combinational fetch slave plus a byte-stream program loader.
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter addr_t BASE_ADDR   = 32'h0000_0000,
  parameter inst_t NOP_INST    = INST_NOP
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_en_i,
  input  addr_t       fetch_addr_i,
  output inst_t       fetch_data_o,
  input  logic        load_start_i,
  input  logic [15:0] load_len_i,
  input  logic        load_valid_i,
  input  logic [7:0]  load_byte_i,
  output logic        load_ready_o,
  output logic        load_busy_o,
  output logic        load_done_o,
  output logic        load_err_o
);

  localparam int          IDX_W   = $clog2(DEPTH_WORDS);
  localparam int          WCNT_W  = IDX_W + 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);
  localparam addr_t       SPAN    = addr_t'(DEPTH_WORDS * 4);

  inst_t mem [DEPTH_WORDS];

  loader_state_t     state_q, state_d;
  logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [WCNT_W-1:0] len_q, len_d;
  logic              err_q, err_d;
  logic              clear;
  logic              accept;
  inst_t             word;
  logic              word_valid;
  addr_t             offset;
  logic              hit;

  assign accept = load_valid_i && load_ready_o;

  inst_rom_byte_word_packer u_packer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear),
    .byte_valid_i (accept),
    .byte_i       (load_byte_i),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    len_d        = len_q;
    err_d        = err_q;
    clear        = 1'b0;
    load_ready_o = 1'b0;
    load_busy_o  = 1'b0;
    load_done_o  = 1'b0;
    case (state_q)
      LD_IDLE: begin
        if (load_start_i) begin
          if ({16'b0, load_len_i} > DEPTH_U) begin
            err_d = 1'b1;
          end else begin
            err_d      = 1'b0;
            len_d      = WCNT_W'(load_len_i);
            word_cnt_d = '0;
            clear      = 1'b1;
            state_d    = (load_len_i == '0) ? LD_DONE : LD_LOAD;
          end
        end
      end
      LD_LOAD: begin
        load_ready_o = 1'b1;
        load_busy_o  = 1'b1;
        if (word_valid) begin
          word_cnt_d = word_cnt_q + WCNT_W'(1);
          if (word_cnt_q + WCNT_W'(1) == len_q) begin
            state_d = LD_DONE;
          end
        end
      end
      LD_DONE: begin
        load_done_o = 1'b1;
        state_d     = LD_IDLE;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  assign load_err_o = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= LD_IDLE;
      word_cnt_q <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      err_q      <= err_d;
    end
  end

  // Array has no reset so program contents survive a core reset.
  always_ff @(posedge clk_i) begin
    if (word_valid) begin
      mem[word_cnt_q[IDX_W-1:0]] <= word;
    end
  end

  // Addresses below BASE_ADDR wrap to large offsets and fall out of range.
  assign offset       = fetch_addr_i - BASE_ADDR;
  assign hit          = fetch_en_i && (state_q != LD_LOAD) &&
                        (offset[1:0] == 2'b00) && (offset < SPAN);
  assign fetch_data_o = hit ? mem[offset[IDX_W+1:2]] : NOP_INST;

endmodule

// File: tb/tb_inst_rom.sv
// Randomized scoreboard bench for inst_rom against a word-array reference model.
module tb_inst_rom;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        load_start;
  logic [15:0] load_len;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_ready;
  logic        load_busy;
  logic        load_done;
  logic        load_err;

  inst_rom #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .NOP_INST    (NOP)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .fetch_en_i   (fetch_en),
    .fetch_addr_i (fetch_addr),
    .fetch_data_o (fetch_data),
    .load_start_i (load_start),
    .load_len_i   (load_len),
    .load_valid_i (load_valid),
    .load_byte_i  (load_byte),
    .load_ready_o (load_ready),
    .load_busy_o  (load_busy),
    .load_done_o  (load_done),
    .load_err_o   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } fexp_t;

  fexp_t       fetch_q[$];
  int          done_q[$];
  logic [31:0] ref_mem [DEPTH];
  bit          loading = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Reference fetch: byte offset from base, must be word aligned and inside the array.
  function automatic logic [31:0] ref_fetch(input bit en, input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    if (!en || loading || off < 0 || off >= DEPTH * 4 || (off % 4) != 0) return NOP;
    return ref_mem[off / 4];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_fetch(input logic [31:0] a, input string name);
    fexp_t e;
    fetch_en   = 1'b1;
    fetch_addr = a;
    e.exp      = ref_fetch(1'b1, a);
    e.name     = name;
    fetch_q.push_back(e);
  endtask

  task automatic do_fetch(input logic [31:0] a, input string name);
    issue_fetch(a, name);
    tick;
    fetch_en = 1'b0;
  endtask

  task automatic do_reset;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", {31'b0, load_ready}, 32'd0);
    check("rst_busy",  {31'b0, load_busy},  32'd0);
    check("rst_done",  {31'b0, load_done},  32'd0);
    check("rst_err",   {31'b0, load_err},   32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick;
  endtask

  task automatic load(input int len, input logic [7:0] b[$], input int gap_max,
                      input int rst_after, input bit mid, input bit start_with_byte,
                      input bit junk_after);
    logic [31:0] w;
    w          = '0;
    load_len   = 16'(len);
    load_start = 1'b1;
    if (start_with_byte) begin
      load_valid = 1'b1;
      load_byte  = 8'hEE;
    end
    tick;
    load_start = 1'b0;
    load_valid = 1'b0;
    if (len == 0) begin
      done_q.push_back(cyc);
      tick;
      return;
    end
    loading = 1'b1;
    foreach (b[i]) begin
      repeat ($urandom_range(0, gap_max)) tick;
      load_valid = 1'b1;
      load_byte  = b[i];
      if (i == 0) begin
        check("ready_in_load", {31'b0, load_ready}, 32'd1);
        check("busy_in_load",  {31'b0, load_busy},  32'd1);
      end
      if (mid && i == 5) issue_fetch(BASE, "fetch_during_load");
      if (mid && i == 6) begin
        load_start = 1'b1;
        load_len   = 16'd3;
      end
      tick;
      load_valid = 1'b0;
      load_start = 1'b0;
      fetch_en   = 1'b0;
      w = {w[23:0], b[i]};
      if (i % 4 == 3) ref_mem[i / 4] = w;
      if (rst_after == i + 1) begin
        loading = 1'b0;
        do_reset;
        return;
      end
    end
    loading = 1'b0;
    done_q.push_back(cyc);
    check("ready_in_done", {31'b0, load_ready}, 32'd0);
    if (junk_after) begin
      load_valid = 1'b1;
      load_byte  = 8'h5A;
    end
    tick;
    load_valid = 1'b0;
  endtask

  // Monitor: consumes expectations whenever the DUT presents a fetch or a done pulse.
  always @(negedge clk) begin
    if (fetch_en) begin
      if (fetch_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fetch_unexpected: got %h expected no fetch", fetch_data);
      end else begin
        fexp_t e;
        e = fetch_q.pop_front();
        check(e.name, fetch_data, e.exp);
      end
    end
    if (load_done) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got pulse at cycle %0d expected none", cyc);
      end else begin
        check("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  initial begin
    logic [7:0]  bytes[$];
    logic [31:0] a;
    int          kind;

    rst_n      = 1'b0;
    fetch_en   = 1'b0;
    fetch_addr = '0;
    load_start = 1'b0;
    load_len   = '0;
    load_valid = 1'b0;
    load_byte  = '0;
    #1;
    check("init_ready", {31'b0, load_ready}, 32'd0);
    check("init_busy",  {31'b0, load_busy},  32'd0);
    check("init_err",   {31'b0, load_err},   32'd0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;

    // Two-word program with a fetch and a stray start during the load.
    bytes = '{8'h34, 8'h01, 8'h00, 8'h0A, 8'h34, 8'h02, 8'h00, 8'h14};
    load(2, bytes, 0, -1, 1'b1, 1'b0, 1'b0);
    check("ref_word0", ref_mem[0], 32'h3401000A);
    do_fetch(BASE,     "fetch_w0");
    do_fetch(BASE + 4, "fetch_w1");

    // Full-depth load with random pacing and a dropped byte during DONE.
    bytes.delete();
    for (int i = 0; i < DEPTH * 4; i++) bytes.push_back(8'($urandom));
    load(DEPTH, bytes, 2, -1, 1'b0, 1'b0, 1'b1);

    for (int n = 0; n < 120; n++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0, 1:    a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        2:       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
        3:       a = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 50));
        default: a = 32'($urandom_range(0, 32'hFF)) & ~32'h3;
      endcase
      do_fetch(a, "rand_fetch");
    end

    do_fetch(BASE + 2,                 "fetch_misaligned");
    do_fetch(BASE + 32'(DEPTH * 4),    "fetch_out_of_range");
    do_fetch(BASE + 32'(DEPTH * 4 - 4), "fetch_last_word");
    do_fetch(BASE - 4,                 "fetch_below_base");
    fetch_addr = BASE;
    #1;
    check("fetch_en0", fetch_data, NOP);

    // Idle reset leaves the array intact.
    do_reset;
    do_fetch(BASE, "fetch_after_reset");

    // Oversize request flags an error and stays idle; a zero-length load clears it.
    load_len   = 16'(DEPTH + 1);
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    check("err_set",      {31'b0, load_err},  32'd1);
    check("err_not_busy", {31'b0, load_busy}, 32'd0);
    tick;
    check("err_sticky",   {31'b0, load_err},  32'd1);
    bytes.delete();
    load(0, bytes, 0, -1, 1'b0, 1'b0, 1'b0);
    check("err_cleared",  {31'b0, load_err},  32'd0);
    do_fetch(BASE + 8, "fetch_after_len0");

    // Reset after 6 of 8 bytes: word 0 committed, word 1 untouched.
    bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h11, 8'h22, 8'h33, 8'h44};
    load(2, bytes, 1, 6, 1'b0, 1'b0, 1'b0);
    check("idle_after_rst", {31'b0, load_busy}, 32'd0);
    do_fetch(BASE,     "partial_w0");
    do_fetch(BASE + 4, "partial_w1_kept");

    // Byte presented with load_start is dropped; new load restarts at word 0.
    bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    load(1, bytes, 0, -1, 1'b0, 1'b1, 1'b0);
    check("ref_restart", ref_mem[0], 32'hAABBCCDD);
    do_fetch(BASE,     "restart_w0");
    do_fetch(BASE + 4, "restart_w1");

    tick;
    tick;
    checks++;
    if (done_q.size() != 0 || fetch_q.size() != 0) begin
      errors++;
      $display("FAIL pending_queues: got done=%0d fetch=%0d expected 0 0", done_q.size(), fetch_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
